// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: interface widths and the memory responder state encoding.
package dcache_pkg;

    localparam int unsigned ADDRBITS      = 32;
    localparam int unsigned DATABITS      = 32;
    localparam int unsigned CACHEWORDS    = 8;
    localparam int unsigned CACHEADDRBITS = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StWrite = 2'b01,
        StBurst = 2'b10,
        StDrain = 2'b11
    } resp_state_e;

    // Terminal value of the 16-bit burst word counter.
    function automatic logic [15:0] burst_last(input int unsigned len);
        return 16'(len - 1);
    endfunction

endpackage

// File: rtl/dcache_mem_rdpipe.sv
// Two-stage read return path: an accepted SRAM read strobe becomes mem_valid two cycles later.
module dcache_mem_rdpipe #(
    parameter int unsigned DATABITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rd_fire,
    input  logic [DATABITS-1:0] sram_rdata,
    output logic                inflight,
    output logic                mem_valid,
    output logic [DATABITS-1:0] mem_dataout
);

    logic                stage_q;
    logic                valid_q;
    logic [DATABITS-1:0] data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            stage_q <= rd_fire;
            valid_q <= stage_q;
            // sram_rdata is only meaningful the cycle after an accepted strobe
            if (stage_q) begin
                data_q <= sram_rdata;
            end
        end
    end

    assign inflight    = stage_q;
    assign mem_valid   = valid_q;
    assign mem_dataout = data_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for dcache line fills (fixed bursts) and single-word flush writes.
// Define DCACHE_MEM_RESPONDER_STATS_EN to add the stat_bursts/stat_writes counters.
module dcache_mem_responder
    import dcache_pkg::*;
#(
    parameter int unsigned ADDRBITS     = 32,
    parameter int unsigned DATABITS     = 32,
    parameter int unsigned BURSTLEN     = 8,
    parameter int unsigned SRAMADDRBITS = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDRBITS-1:0]     mem_addr,
    input  logic                    mem_rdreq,
    input  logic                    mem_wrreq,
    input  logic [DATABITS-1:0]     mem_datain,
    output logic [15:0]             mem_burstlen,
    output logic [DATABITS-1:0]     mem_dataout,
    output logic                    mem_valid,
    output logic                    mem_wrack,
    output logic                    busy,
    output logic                    proto_err,
    output logic [SRAMADDRBITS-1:0] sram_addr,
    output logic                    sram_rden,
    output logic                    sram_wren,
    output logic [DATABITS-1:0]     sram_wdata,
    input  logic [DATABITS-1:0]     sram_rdata,
    input  logic                    sram_ready
`ifdef DCACHE_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]             stat_bursts,
    output logic [31:0]             stat_writes
`endif
);

    localparam logic [15:0] LastCnt = burst_last(BURSTLEN);

    resp_state_e             state_q, state_d;
    logic [SRAMADDRBITS-1:0] addr_q, addr_d;
    logic [DATABITS-1:0]     wdata_q, wdata_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    rden_q, rden_d;
    logic                    wren_q, wren_d;
    logic                    wrack_q, wrack_d;
    logic                    perr_q, perr_d;
    logic                    busy_q;

    logic [SRAMADDRBITS-1:0] req_word;
    logic                    rd_fire;
    logic                    wr_fire;
    logic                    last_strobe;
    logic                    pipe_inflight;
    logic                    unused_addr_bits;

    assign req_word         = mem_addr[SRAMADDRBITS+1:2];
    assign unused_addr_bits = ^{mem_addr[ADDRBITS-1:SRAMADDRBITS+2], mem_addr[1:0]};

    // Strobes are held until the SRAM takes them; only accepted strobes advance the burst.
    assign rd_fire     = rden_q & sram_ready;
    assign wr_fire     = wren_q & sram_ready;
    assign last_strobe = rd_fire && (cnt_q == LastCnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            wrack_q <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            wrack_q <= wrack_d;
            perr_q  <= perr_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mem_wrreq) begin
                    state_d = StWrite;
                end else if (mem_rdreq) begin
                    state_d = StBurst;
                end
            end
            StWrite: begin
                if (wr_fire) begin
                    state_d = StIdle;
                end
            end
            StBurst: begin
                if (last_strobe) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Last word leaves while nothing is left in the return pipe
                if (mem_valid && !pipe_inflight) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rden_d  = rden_q;
        wren_d  = wren_q;
        wrack_d = 1'b0;
        perr_d  = perr_q;
        unique case (state_q)
            StIdle: begin
                if (mem_wrreq) begin
                    addr_d  = req_word;
                    wdata_d = mem_datain;
                    wren_d  = 1'b1;
                    if (mem_rdreq) begin
                        perr_d = 1'b1;
                    end
                end else if (mem_rdreq) begin
                    addr_d = req_word;
                    cnt_d  = '0;
                    rden_d = 1'b1;
                end
            end
            StWrite: begin
                if (wr_fire) begin
                    wren_d  = 1'b0;
                    wrack_d = 1'b1;
                end
            end
            StBurst: begin
                if (rd_fire) begin
                    addr_d = addr_q + SRAMADDRBITS'(1);
                    cnt_d  = cnt_q + 16'd1;
                    if (last_strobe) begin
                        rden_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        if ((state_q != StIdle) && (mem_rdreq || mem_wrreq)) begin
            perr_d = 1'b1;
        end
    end

    dcache_mem_rdpipe #(
        .DATABITS (DATABITS)
    ) u_rdpipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_fire     (rd_fire),
        .sram_rdata  (sram_rdata),
        .inflight    (pipe_inflight),
        .mem_valid   (mem_valid),
        .mem_dataout (mem_dataout)
    );

    assign mem_burstlen = 16'(BURSTLEN);
    assign mem_wrack    = wrack_q;
    assign busy         = busy_q;
    assign proto_err    = perr_q;
    assign sram_addr    = addr_q;
    assign sram_rden    = rden_q;
    assign sram_wren    = wren_q;
    assign sram_wdata   = wdata_q;

`ifdef DCACHE_MEM_RESPONDER_STATS_EN
    logic [31:0] stat_bursts_q;
    logic [31:0] stat_writes_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_bursts_q <= '0;
            stat_writes_q <= '0;
        end else begin
            if (state_q == StBurst && state_d == StDrain) begin
                stat_bursts_q <= stat_bursts_q + 32'd1;
            end
            if (wrack_q) begin
                stat_writes_q <= stat_writes_q + 32'd1;
            end
        end
    end

    assign stat_bursts = stat_bursts_q;
    assign stat_writes = stat_writes_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Randomized self-checking bench for dcache_mem_responder with a behavioural SRAM and reference memory.
module tb_dcache_mem_responder;

    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_rdreq = 1'b0;
    logic        mem_wrreq = 1'b0;
    logic [31:0] mem_datain = '0;
    logic [15:0] mem_burstlen;
    logic [31:0] mem_dataout;
    logic        mem_valid;
    logic        mem_wrack;
    logic        busy;
    logic        proto_err;
    logic [15:0] sram_addr;
    logic        sram_rden;
    logic        sram_wren;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic        sram_ready = 1'b1;
`ifdef DCACHE_MEM_RESPONDER_STATS_EN
    logic [31:0] stat_bursts;
    logic [31:0] stat_writes;
`endif

    always #5 clk = ~clk;

    dcache_mem_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_addr     (mem_addr),
        .mem_rdreq    (mem_rdreq),
        .mem_wrreq    (mem_wrreq),
        .mem_datain   (mem_datain),
        .mem_burstlen (mem_burstlen),
        .mem_dataout  (mem_dataout),
        .mem_valid    (mem_valid),
        .mem_wrack    (mem_wrack),
        .busy         (busy),
        .proto_err    (proto_err),
        .sram_addr    (sram_addr),
        .sram_rden    (sram_rden),
        .sram_wren    (sram_wren),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
`ifdef DCACHE_MEM_RESPONDER_STATS_EN
        ,
        .stat_bursts  (stat_bursts),
        .stat_writes  (stat_writes)
`endif
    );

    int cyc = 0;
    int t0 = 0;
    int n_tests = 0;
    int n_fail = 0;
    int exp_bursts = 0;
    int exp_writes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Backing SRAM as seen by the DUT, plus the reference view of what it should hold.
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    int rd_addr[$];
    int rd_rel[$];
    int wr_addr[$];
    int wr_rel[$];
    logic [31:0] wr_data[$];

    initial begin : sram_model
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i * 3);
        forever begin
            @(posedge clk);
            if (sram_rden && sram_ready) begin
                sram_rdata <= mem[sram_addr];
                rd_addr.push_back(int'(sram_addr));
                rd_rel.push_back(cyc - t0 + 1);
            end
            if (sram_wren && sram_ready) begin
                mem[sram_addr] = sram_wdata;
                wr_addr.push_back(int'(sram_addr));
                wr_data.push_back(sram_wdata);
                wr_rel.push_back(cyc - t0 + 1);
            end
        end
    end

    logic [31:0] got_data[$];
    int got_rel[$];
    int wrack_rel[$];
    int busy_fall[$];
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_valid) begin
            got_data.push_back(mem_dataout);
            got_rel.push_back(cyc - t0 + 1);
        end
        if (mem_wrack) wrack_rel.push_back(cyc - t0 + 1);
        if (busy_prev && !busy) busy_fall.push_back(cyc - t0 + 1);
        busy_prev = busy;
    end

    // 0: always ready, 1: low in cycles flagged in stall_mask, 2: random ~70% ready
    int ready_mode = 0;
    logic [31:0] stall_mask = '0;

    initial begin : ready_driver
        forever begin
            int rel;
            @(posedge clk);
            #2;
            rel = cyc - t0 + 1;
            case (ready_mode)
                1: sram_ready = !(rel >= 0 && rel < 32 && stall_mask[rel]);
                2: sram_ready = ($urandom_range(0, 9) < 7);
                default: sram_ready = 1'b1;
            endcase
        end
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_bursts = 0;
        exp_writes = 0;
    endtask

    task automatic start_req(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data);
        @(posedge clk);
        #1;
        got_data.delete(); got_rel.delete(); wrack_rel.delete(); busy_fall.delete();
        rd_addr.delete(); rd_rel.delete(); wr_addr.delete(); wr_rel.delete(); wr_data.delete();
        mem_addr = addr;
        mem_rdreq = rd;
        mem_wrreq = wr;
        mem_datain = data;
        @(posedge clk);
        #1;
        t0 = cyc;
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " idle"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_burst(input string tag, input int word);
        logic [31:0] got;
        check_eq({tag, " words"}, got_data.size(), BL);
        check_eq({tag, " strobes"}, rd_addr.size(), BL);
        for (int k = 0; k < BL; k++) begin
            got = (k < got_data.size()) ? got_data[k] : 'x;
            check_eq($sformatf("%s data[%0d]", tag, k), got, ref_mem[(word + k) & 16'hFFFF]);
            check_eq($sformatf("%s addr[%0d]", tag, k), qget(rd_addr, k), (word + k) & 16'hFFFF);
        end
        exp_bursts++;
    endtask

    task automatic check_write(input string tag, input int word, input logic [31:0] data);
        check_eq({tag, " wr count"}, wr_addr.size(), 1);
        check_eq({tag, " wr addr"}, qget(wr_addr, 0), word);
        check_eq({tag, " wr data"}, (wr_data.size() > 0) ? wr_data[0] : 'x, data);
        check_eq({tag, " wrack count"}, wrack_rel.size(), 1);
        check_eq({tag, " wrack timing"}, qget(wrack_rel, 0), qget(wr_rel, 0) + 1);
        ref_mem[word] = data;
        exp_writes++;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int strobes;
        int n;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 32'(i * 3);

        // Reset and idle behaviour
        apply_reset();
        check_eq("rst burstlen", 32'(mem_burstlen), 32'd8);
        check_eq("rst valid", 32'(mem_valid), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst proto_err", 32'(proto_err), 32'd0);
        check_eq("rst wrack", 32'(mem_wrack), 32'd0);
        strobes = 0;
        repeat (20) begin
            @(negedge clk);
            if (sram_rden || sram_wren) strobes++;
        end
        check_eq("idle strobes", strobes, 0);

        // Unstalled burst at 0x40
        ready_mode = 0;
        start_req(1'b1, 1'b0, 32'h40, '0);
        wait_idle("burst");
        check_burst("burst", 16'h10);
        check_eq("burst first valid cyc", qget(got_rel, 0), 3);
        check_eq("burst last valid cyc", qget(got_rel, BL - 1), 10);
        check_eq("burst busy fall cyc", qget(busy_fall, 0), 11);

        // Same burst, SRAM not ready in cycles 2 and 5
        ready_mode = 1;
        stall_mask = (32'd1 << 2) | (32'd1 << 5);
        start_req(1'b1, 1'b0, 32'h40, '0);
        wait_idle("stall");
        check_burst("stall", 16'h10);
        check_eq("stall last valid cyc", qget(got_rel, BL - 1), 12);
        check_eq("stall gaps", qget(got_rel, BL - 1) - qget(got_rel, 0) + 1 - BL, 2);

        // Write with SRAM busy for three cycles, then read it back
        stall_mask = 32'b1110;
        start_req(1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
        wait_idle("write");
        check_write("write", 16'h40, 32'hDEADBEEF);
        check_eq("write accept cyc", qget(wr_rel, 0), 4);
        ready_mode = 0;
        start_req(1'b1, 1'b0, 32'h100, '0);
        wait_idle("readback");
        check_eq("readback word0", (got_data.size() > 0) ? got_data[0] : 'x, 32'hDEADBEEF);
        check_burst("readback", 16'h40);

        // Read request while busy is dropped and flagged
        apply_reset();
        start_req(1'b1, 1'b0, 32'h200, '0);
        repeat (2) @(posedge clk);
        #1;
        mem_addr = 32'h600;
        mem_rdreq = 1'b1;
        @(posedge clk);
        #1;
        mem_rdreq = 1'b0;
        wait_idle("busyreq");
        check_burst("busyreq", 16'h80);
        check_eq("busyreq proto_err", 32'(proto_err), 32'd1);

        // Simultaneous read+write in idle: write wins
        apply_reset();
        check_eq("both proto_err pre", 32'(proto_err), 32'd0);
        start_req(1'b1, 1'b1, 32'h300, 32'hCAFEF00D);
        wait_idle("both");
        check_write("both", 16'hC0, 32'hCAFEF00D);
        check_eq("both strobes", rd_addr.size(), 0);
        check_eq("both valids", got_data.size(), 0);
        check_eq("both proto_err", 32'(proto_err), 32'd1);
        check_eq("both sram content", mem[16'hC0], 32'hCAFEF00D);

        // Address wrap at the top of the SRAM
        start_req(1'b1, 1'b0, 32'h3FFF8, '0);
        wait_idle("wrap");
        check_burst("wrap", 16'hFFFE);
        check_eq("wrap no gap", qget(rd_rel, BL - 1) - qget(rd_rel, 0), BL - 1);

`ifdef DCACHE_MEM_RESPONDER_STATS_EN
        check_eq("stat bursts mid", stat_bursts, exp_bursts);
        check_eq("stat writes mid", stat_writes, exp_writes);
`endif

        // Reset in the middle of a burst
        start_req(1'b1, 1'b0, 32'h80, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_valid && n < 20);
        check_eq("midrst valid before", 32'(mem_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("midrst valid", 32'(mem_valid), 32'd0);
        check_eq("midrst busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_bursts = 0;
        exp_writes = 0;
        got_data.delete();
        repeat (15) @(negedge clk);
        check_eq("midrst valids after", got_data.size(), 0);
        check_eq("midrst busy after", 32'(busy), 32'd0);

        // Random traffic with random SRAM backpressure
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            int w;
            a = $urandom();
            d = $urandom();
            if ($urandom_range(0, 2) == 0) begin
                w = $urandom_range(0, 63);
                a[17:2] = 16'(w);
                start_req(1'b0, 1'b1, a, d);
                wait_idle($sformatf("rnd%0d", i));
                check_write($sformatf("rnd%0d", i), w, d);
            end else begin
                w = ($urandom_range(0, 7) == 0) ? 16'hFFFC : $urandom_range(0, 60);
                a[17:2] = 16'(w);
                start_req(1'b1, 1'b0, a, '0);
                wait_idle($sformatf("rnd%0d", i));
                check_burst($sformatf("rnd%0d", i), w);
            end
        end
        check_eq("rnd proto_err", 32'(proto_err), 32'd0);

`ifdef DCACHE_MEM_RESPONDER_STATS_EN
        check_eq("stat bursts", stat_bursts, exp_bursts);
        check_eq("stat writes", stat_writes, exp_writes);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the data-cache fill/flush interface: serves line fills as fixed-length bursts (mem_rdreq -> mem_burstlen words on mem_dataout/mem_valid) and single-word flush writes.
- Sits between the dcache line controllers and a synchronous single-port backing SRAM with fixed 1-cycle read latency and a ready backpressure input.

Parameters:
- ADDRBITS, 32, byte-address width on the cache side
- DATABITS, 32, data word width
- BURSTLEN, 8, words per read burst (legal 1..32768); driven on mem_burstlen
- SRAMADDRBITS, 16, word-address width of the backing SRAM

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mem_addr  in  ADDRBITS  byte address of burst start or write word; bits[1:0] ignored
- mem_rdreq  in  1  single-cycle burst read request
- mem_wrreq  in  1  single-cycle word write request
- mem_datain  in  DATABITS  write data, sampled with mem_wrreq
- mem_burstlen  out  16  constant BURSTLEN
- mem_dataout  out  DATABITS  read data
- mem_valid  out  1  mem_dataout valid this cycle
- mem_wrack  out  1  one-cycle pulse: write committed to SRAM
- busy  out  1  high in any state except IDLE
- proto_err  out  1  sticky: request dropped
- sram_addr  out  SRAMADDRBITS  word address = byte address[SRAMADDRBITS+1:2]
- sram_rden  out  1  read strobe; sram_rdata valid the following cycle
- sram_wren  out  1  write strobe
- sram_wdata  out  DATABITS  write data
- sram_rdata  in  DATABITS  read data
- sram_ready  in  1  SRAM accepts a strobe this cycle

Behaviour:
- Reset: all outputs 0 except mem_burstlen=BURSTLEN; state IDLE; counters and pipeline cleared. Reset mid-burst abandons the burst; no further mem_valid.
- All outputs are registered. States: IDLE, WRITE, BURST, DRAIN.
- IDLE:
  - mem_wrreq: latch addr/data, go to WRITE.
  - Otherwise mem_rdreq: latch word address, clear cnt, go to BURST.
  - Both asserted: the write wins, the read is dropped, proto_err set.
- WRITE: when sram_ready=1, issue sram_wren with latched addr/data for one cycle. mem_wrack pulses in the following cycle; return to IDLE.
- BURST:
  - Each cycle with sram_ready=1: sram_rden=1 at the current word address; address +1 (wraps modulo 2^SRAMADDRBITS); cnt +1.
  - After the BURSTLEN-th strobe, go to DRAIN.
  - sram_ready=0: no strobe; address and cnt hold.
- Read pipeline: rden at cycle n -> sram_rdata at n+1 -> mem_dataout/mem_valid registered at n+2.
  - Minimum latency: mem_rdreq sampled at edge 0 -> first mem_valid in cycle 3.
  - Unstalled burst: BURSTLEN consecutive mem_valid cycles. Stalls produce gaps; the word count is always exactly BURSTLEN.
- DRAIN: wait until the last mem_valid is output, then go to IDLE. The next request is acceptable in the cycle after the last mem_valid.
- Any mem_rdreq/mem_wrreq while busy=1: ignored, proto_err set (cleared only by reset).
- cnt is 16 bits; comparison against BURSTLEN-1 is done at full width.

Optional Feature:
- Macro DCACHE_MEM_RESPONDER_STATS_EN.
- Defined: adds outputs stat_bursts[31:0] (+1 on each BURST->DRAIN transition) and stat_writes[31:0] (+1 on each mem_wrack). Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dcache_pkg:
  - address/data width constants (ADDRBITS, DATABITS, CACHEWORDS, CACHEADDRBITS)
  - responder state encoding (IDLE=2'b00, WRITE=2'b01, BURST=2'b10, DRAIN=2'b11)
- Sub-module dcache_mem_rdpipe: the 2-stage rden->valid/data delay line. The FSM/address counter stays in the top module.

Test Plan:
- Reset then idle: mem_burstlen=8, mem_valid=0, busy=0, proto_err=0; sram strobes stay 0 for 20 cycles.
- SRAM preloaded word[i]=i*3, sram_ready=1, mem_rdreq with mem_addr=0x40 -> sram_addr 0x10..0x17; mem_valid in cycles 3..10 with data 0x30,0x33,...,0x45; busy falls in cycle 11.
- Same burst with sram_ready=0 in cycles 2 and 5 -> exactly 8 mem_valid words, in order, ending in cycle 12 with two single-cycle gaps.
- mem_wrreq addr=0x100 data=0xDEADBEEF with sram_ready low for 3 cycles -> one sram_wren at sram_addr 0x40 once ready, mem_wrack one cycle later; a following read of 0x100 returns 0xDEADBEEF.
- mem_rdreq during BURST, then mem_rdreq+mem_wrreq together in IDLE -> first burst unaffected, proto_err=1, only the write executed.
- Burst from mem_addr=0x3FFF8 with SRAMADDRBITS=16 -> sram_addr 0xFFFE,0xFFFF,0x0000,... with no gap; assert reset_n low mid-burst -> mem_valid 0 immediately and stays 0 after release.
